// File: rtl/cpu_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding,
// operation select, and default sizing / exception constants.
package cpu_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int REG_W_DEF       = 5;
    localparam int RSTATUS_IDX_DEF = 30;
    localparam int MULT_EXC_DEF    = 4;
    localparam int DIV_EXC_DEF     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

endpackage

// File: rtl/multdiv_iter_core.sv
// Iterative datapath for the multiply/divide sequencer. Works on unsigned
// magnitudes, one bit per step: shift/add for multiply, restoring
// subtract/shift for divide. The sign is applied to the result at the end.
// MULTDIV_EARLY_OUT_EN: when defined, `skip` flags a zero operand
// (multiply) or a zero divisor (divide) so the sequencer can finish early.
module multdiv_iter_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              load,
    input  logic              step,
    input  op_e               op_sel,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic [DATA_W-1:0] result,
    output logic              exc,
    output logic              is_div,
    output logic              skip
);

    // acc: product high half / partial remainder; lo: multiplier / quotient
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic              neg_q, neg_d;
    logic              div_q, div_d;
    logic              div0_q, div0_d;

    logic [DATA_W-1:0]   mag_a, mag_b;
    logic                mult_zero, b_zero;
    logic [DATA_W:0]     sum, rem_sh, diff;
    logic [2*DATA_W-1:0] prod, sprod;
    logic [DATA_W-1:0]   quo;

    // Load operands on accept, otherwise advance one iteration per step
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        acc_d  = acc_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        neg_d  = neg_q;
        div_d  = div_q;
        div0_d = div0_q;

        mag_a     = operand_a[DATA_W-1] ? -operand_a : operand_a;
        mag_b     = operand_b[DATA_W-1] ? -operand_b : operand_b;
        b_zero    = (operand_b == '0);
        mult_zero = (operand_a == '0) || b_zero;

        sum    = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
        rem_sh = {acc_q, lo_q[DATA_W-1]};
        diff   = rem_sh - {1'b0, opnd_q};

        if (load) begin
            acc_d  = '0;
            neg_d  = operand_a[DATA_W-1] ^ operand_b[DATA_W-1];
            div_d  = (op_sel == OP_DIV);
            div0_d = (op_sel == OP_DIV) && b_zero;
            if (op_sel == OP_MULT) begin
                opnd_d = mag_a;
                // A zero multiplier keeps the product zero even if iteration is cut short
                lo_d   = mult_zero ? '0 : mag_b;
            end else begin
                opnd_d = mag_b;
                lo_d   = mag_a;
            end
        end else if (step) begin
            if (!div_q) begin
                acc_d = sum[DATA_W:1];
                lo_d  = {sum[0], lo_q[DATA_W-1:1]};
            end else begin
                acc_d = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
                lo_d  = {lo_q[DATA_W-2:0], ~diff[DATA_W]};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        // NOTE: datapath registers carry no reset; they are always loaded before being observed.
        acc_q  <= acc_d;
        lo_q   <= lo_d;
        opnd_q <= opnd_d;
        neg_q  <= neg_d;
        div_q  <= div_d;
        div0_q <= div0_d;
    end

`ifdef MULTDIV_EARLY_OUT_EN
    logic skip_q, skip_d;

    // Remember whether the accepted operation can finish without iterating
    always_comb begin
        skip_d = skip_q;
        if (load) skip_d = (op_sel == OP_DIV) ? b_zero : mult_zero;
    end

    // Early-out flag register
    always_ff @(posedge clock) begin
        skip_q <= skip_d;
    end

    assign skip = skip_q;
`else
    assign skip = 1'b0;
`endif

    // Sign fix-up and overflow / divide-by-zero detection
    always_comb begin
        prod   = {acc_q, lo_q};
        sprod  = neg_q ? -prod : prod;
        quo    = neg_q ? -lo_q : lo_q;
        result = div_q ? quo : sprod[DATA_W-1:0];
        exc    = div_q ? div0_q
                       : (sprod[2*DATA_W-1:DATA_W] != {DATA_W{sprod[DATA_W-1]}});
        is_div = div_q;
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply/divide unit. Accepts a start from decode while
// idle, stalls the pipeline for DATA_W iterations, then issues one writeback
// beat to rd, or to the rstatus register when the operation raised an exception.
// MULTDIV_EARLY_OUT_EN: when defined, trivial operands finish after one iteration.
module multdiv_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int REG_W       = REG_W_DEF,
    parameter int RSTATUS_IDX = RSTATUS_IDX_DEF,
    parameter int MULT_EXC    = MULT_EXC_DEF,
    parameter int DIV_EXC     = DIV_EXC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [REG_W-1:0]  rd_in,
    output logic              stall,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              exception
);

    localparam int               CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [REG_W-1:0]  rd_q, rd_d;

    logic              start_any, load, step, done;
    op_e               op_sel;
    logic [DATA_W-1:0] core_result;
    logic              core_exc, core_is_div, core_skip;

    assign start_any = start_mult | start_div;
    assign op_sel    = start_mult ? OP_MULT : OP_DIV;

    multdiv_iter_core #(.DATA_W(DATA_W)) u_core (
        .clock     (clock),
        .load      (load),
        .step      (step),
        .op_sel    (op_sel),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (core_result),
        .exc       (core_exc),
        .is_div    (core_is_div),
        .skip      (core_skip)
    );

    // Next-state logic: accept in IDLE, iterate DATA_W times, one DONE beat
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rd_d    = rd_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_any) begin
                    load    = 1'b1;
                    rd_d    = rd_in;
                    count_d = '0;
                    state_d = start_mult ? ST_MULT : ST_DIV;
                end
            end
            ST_MULT, ST_DIV: begin
                step    = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST || core_skip) state_d = ST_DONE;
            end
            ST_DONE: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers with synchronous reset
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
        end
    end

    // Pipeline hold and writeback beat decode
    always_comb begin
        done      = (state_q == ST_DONE);
        stall     = ((state_q == ST_IDLE) && start_any) ||
                    (state_q == ST_MULT) || (state_q == ST_DIV);
        wb_valid  = done;
        exception = done && core_exc;
        wb_rd     = '0;
        wb_data   = '0;
        if (done) begin
            if (core_exc) begin
                wb_rd   = REG_W'(RSTATUS_IDX);
                wb_data = core_is_div ? DATA_W'(DIV_EXC) : DATA_W'(MULT_EXC);
            end else begin
                wb_rd   = rd_q;
                wb_data = core_result;
            end
        end
    end

endmodule
